// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares the single-port data memory between the CPU MEM
// stage and the NoC network interface. The CPU has priority. A saturating
// starvation counter lets a waiting NI win once it has waited STARVE_LIMIT cycles.
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  MEM_DATA_MEM_READ,
  input  logic [2:0]  MEM_DATA_MEM_WRITE,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_WRITE_DATA,
  output logic [31:0] MEM_READ_DATA,
  output logic        MEM_STALL,
  input  logic        NI_REQ,
  input  logic        NI_WE,
  input  logic [31:0] NI_ADDR,
  input  logic [31:0] NI_WDATA,
  output logic [31:0] NI_RDATA,
  output logic        NI_DONE,
  output logic [3:0]  DM_READ,
  output logic [2:0]  DM_WRITE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WDATA,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, NI_ACC} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ni_we_q, ni_we_d;
  logic [31:0]      ni_addr_q, ni_addr_d;
  logic [31:0]      ni_wdata_q, ni_wdata_d;

  logic cpu_req;
  logic cnt_sat;

  assign cpu_req = MEM_DATA_MEM_READ[3] | MEM_DATA_MEM_WRITE[2];
  assign cnt_sat = (cnt_q == CNT_W'(STARVE_LIMIT));

  // State, starvation counter and NI request latches.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ni_we_q    <= 1'b0;
      ni_addr_q  <= '0;
      ni_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ni_we_q    <= ni_we_d;
      ni_addr_q  <= ni_addr_d;
      ni_wdata_q <= ni_wdata_d;
    end
  end

  // Next-state: grant from IDLE only; an access ends on the first non-busy edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ni_we_d    = ni_we_q;
    ni_addr_d  = ni_addr_q;
    ni_wdata_d = ni_wdata_q;
    // NI waiting (anything but being served) ages the counter up to the limit.
    if (NI_REQ && (state_q != NI_ACC) && !cnt_sat)
      cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (NI_REQ && (!cpu_req || cnt_sat)) begin
          state_d    = NI_ACC;
          ni_we_d    = NI_WE;
          ni_addr_d  = NI_ADDR;
          ni_wdata_d = NI_WDATA;
          cnt_d      = '0;   // grant clears, overriding the increment above
        end else if (cpu_req) begin
          state_d = CPU_ACC;
        end
      end
      CPU_ACC: if (!DM_BUSYWAIT) state_d = IDLE;
      NI_ACC:  if (!DM_BUSYWAIT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output mux. Everything is held at 0 while reset is asserted, so an
  // abandoned access drops its memory controls immediately.
  always_comb begin
    DM_READ       = '0;
    DM_WRITE      = '0;
    DM_ADDR       = '0;
    DM_WDATA      = '0;
    MEM_STALL     = 1'b0;
    MEM_READ_DATA = '0;
    NI_RDATA      = '0;
    NI_DONE       = 1'b0;
    if (RESET) begin
      case (state_q)
        CPU_ACC: begin
          // Live CPU controls; the stall keeps them stable until completion.
          DM_READ  = MEM_DATA_MEM_READ;
          DM_WRITE = MEM_DATA_MEM_WRITE;
          DM_ADDR  = MEM_ALU_OUT;
          DM_WDATA = MEM_WRITE_DATA;
        end
        NI_ACC: begin
          DM_READ  = ni_we_q ? 4'b0000 : 4'b1010;
          DM_WRITE = ni_we_q ? 3'b110  : 3'b000;
          DM_ADDR  = ni_addr_q;
          DM_WDATA = ni_wdata_q;
        end
        default: ;
      endcase
      MEM_STALL     = cpu_req & !((state_q == CPU_ACC) & !DM_BUSYWAIT);
      MEM_READ_DATA = DM_RDATA;
      NI_RDATA      = DM_RDATA;
      NI_DONE       = (state_q == NI_ACC) & !DM_BUSYWAIT;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: reset, CPU load/store, NI write/read,
// contention with starvation guard, simultaneous requests, reset mid-access.
module tb_data_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  MEM_DATA_MEM_READ;
  logic [2:0]  MEM_DATA_MEM_WRITE;
  logic [31:0] MEM_ALU_OUT, MEM_WRITE_DATA, MEM_READ_DATA;
  logic        MEM_STALL;
  logic        NI_REQ, NI_WE;
  logic [31:0] NI_ADDR, NI_WDATA, NI_RDATA;
  logic        NI_DONE;
  logic [3:0]  DM_READ;
  logic [2:0]  DM_WRITE;
  logic [31:0] DM_ADDR, DM_WDATA, DM_RDATA;
  logic        DM_BUSYWAIT;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_DATA_MEM_READ(MEM_DATA_MEM_READ), .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE),
    .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_READ_DATA(MEM_READ_DATA), .MEM_STALL(MEM_STALL),
    .NI_REQ(NI_REQ), .NI_WE(NI_WE), .NI_ADDR(NI_ADDR), .NI_WDATA(NI_WDATA),
    .NI_RDATA(NI_RDATA), .NI_DONE(NI_DONE),
    .DM_READ(DM_READ), .DM_WRITE(DM_WRITE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_RDATA(DM_RDATA), .DM_BUSYWAIT(DM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the posedge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    MEM_DATA_MEM_READ = '0; MEM_DATA_MEM_WRITE = '0; MEM_ALU_OUT = '0; MEM_WRITE_DATA = '0;
    NI_REQ = 1'b0; NI_WE = 1'b0; NI_ADDR = '0; NI_WDATA = '0;
    DM_RDATA = '0; DM_BUSYWAIT = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b0;
    MEM_DATA_MEM_READ = 4'b1010; NI_REQ = 1'b1; DM_RDATA = 32'hCAFEF00D;
    tick(); tick(); #1;
    n_tests++; if (MEM_STALL !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b exp 0", MEM_STALL); end
    n_tests++; if (MEM_READ_DATA !== 32'h0) begin n_fail++; $display("FAIL rst_mem_rdata: got %h exp 0", MEM_READ_DATA); end
    n_tests++; if (NI_RDATA !== 32'h0 || NI_DONE !== 1'b0) begin n_fail++; $display("FAIL rst_ni: rdata %h done %0b exp 0/0", NI_RDATA, NI_DONE); end
    n_tests++; if (DM_READ !== 4'h0 || DM_WRITE !== 3'h0 || DM_ADDR !== 32'h0 || DM_WDATA !== 32'h0) begin
      n_fail++; $display("FAIL rst_dm: rd %h wr %h addr %h wd %h exp all 0", DM_READ, DM_WRITE, DM_ADDR, DM_WDATA); end
    n_tests++; if (dut.cnt_q !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", dut.cnt_q); end
    idle_inputs();
    tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_cpu_lw();
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h40; DM_RDATA = 32'hDEADBEEF; DM_BUSYWAIT = 1'b0;
    #1;
    n_tests++; if (MEM_STALL !== 1'b1) begin n_fail++; $display("FAIL lw_idle_stall: got %0b exp 1", MEM_STALL); end
    n_tests++; if (DM_READ !== 4'b0000) begin n_fail++; $display("FAIL lw_idle_dmread: got %b exp 0000", DM_READ); end
    tick(); #1;
    n_tests++; if (MEM_STALL !== 1'b0) begin n_fail++; $display("FAIL lw_acc_stall: got %0b exp 0", MEM_STALL); end
    n_tests++; if (DM_READ !== 4'b1010 || DM_ADDR !== 32'h40) begin n_fail++; $display("FAIL lw_acc_dm: rd %b addr %h exp 1010/40", DM_READ, DM_ADDR); end
    n_tests++; if (MEM_READ_DATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h exp deadbeef", MEM_READ_DATA); end
    tick();
    idle_inputs();
    #1;
    n_tests++; if (DM_READ !== 4'b0000 || MEM_STALL !== 1'b0) begin n_fail++; $display("FAIL lw_after: rd %b stall %0b exp 0000/0", DM_READ, MEM_STALL); end
  endtask

  task automatic test_cpu_sw_busy();
    int writes = 0;
    MEM_DATA_MEM_WRITE = 3'b110; MEM_ALU_OUT = 32'h80; MEM_WRITE_DATA = 32'h1234; DM_BUSYWAIT = 1'b1;
    #1;
    n_tests++; if (MEM_STALL !== 1'b1 || DM_WRITE !== 3'b000) begin n_fail++; $display("FAIL sw_idle: stall %0b wr %b exp 1/000", MEM_STALL, DM_WRITE); end
    for (int i = 0; i < 4; i++) begin
      tick();
      DM_BUSYWAIT = (i < 3);
      #1;
      n_tests++; if (DM_WRITE !== 3'b110 || DM_WDATA !== 32'h1234) begin n_fail++; $display("FAIL sw_hold[%0d]: wr %b wd %h exp 110/1234", i, DM_WRITE, DM_WDATA); end
      n_tests++; if (MEM_STALL !== (i < 3)) begin n_fail++; $display("FAIL sw_stall[%0d]: got %0b exp %0b", i, MEM_STALL, (i < 3)); end
      if (DM_WRITE[2] && !DM_BUSYWAIT) writes++;
    end
    // Store is still presented for one more cycle; FSM must be back in IDLE.
    tick(); #1;
    n_tests++; if (DM_WRITE !== 3'b000 || MEM_STALL !== 1'b1) begin n_fail++; $display("FAIL sw_back_idle: wr %b stall %0b exp 000/1", DM_WRITE, MEM_STALL); end
    if (DM_WRITE[2] && !DM_BUSYWAIT) writes++;
    idle_inputs();
    n_tests++; if (writes != 1) begin n_fail++; $display("FAIL sw_count: got %0d exp 1", writes); end
    tick(); tick();
  endtask

  task automatic test_ni_write();
    NI_REQ = 1'b1; NI_WE = 1'b1; NI_ADDR = 32'h100; NI_WDATA = 32'h5;
    #1;
    n_tests++; if (NI_DONE !== 1'b0 || DM_WRITE !== 3'b000 || MEM_STALL !== 1'b0) begin
      n_fail++; $display("FAIL niw_idle: done %0b wr %b stall %0b exp 0/000/0", NI_DONE, DM_WRITE, MEM_STALL); end
    tick();
    NI_WDATA = 32'hFFFF_FFFF; NI_ADDR = 32'h999;  // latched copy must be used
    #1;
    n_tests++; if (DM_WRITE !== 3'b110 || DM_READ !== 4'b0000 || DM_WDATA !== 32'h5 || DM_ADDR !== 32'h100) begin
      n_fail++; $display("FAIL niw_acc: wr %b rd %b wd %h addr %h exp 110/0000/5/100", DM_WRITE, DM_READ, DM_WDATA, DM_ADDR); end
    n_tests++; if (NI_DONE !== 1'b1 || MEM_STALL !== 1'b0) begin n_fail++; $display("FAIL niw_done: done %0b stall %0b exp 1/0", NI_DONE, MEM_STALL); end
    n_tests++; if (dut.cnt_q !== 4'd0) begin n_fail++; $display("FAIL niw_cnt: got %0d exp 0", dut.cnt_q); end
    tick();
    idle_inputs();
    #1;
    n_tests++; if (NI_DONE !== 1'b0 || DM_WRITE !== 3'b000) begin n_fail++; $display("FAIL niw_after: done %0b wr %b exp 0/000", NI_DONE, DM_WRITE); end
    tick();
  endtask

  task automatic test_contention();
    // Expected per cycle: IDLE, CPU, IDLE, CPU, IDLE (cnt=4), NI read.
    logic [3:0]  exp_rd   [6] = '{4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b1010};
    logic [31:0] exp_addr [6] = '{32'h0, 32'h44, 32'h0, 32'h44, 32'h0, 32'h200};
    logic        exp_stall[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        exp_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  exp_cnt  [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h44; DM_RDATA = 32'h0BAD_CAFE;
    NI_REQ = 1'b1; NI_WE = 1'b0; NI_ADDR = 32'h200;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) tick();
      #1;
      n_tests++; if (DM_READ !== exp_rd[c] || DM_ADDR !== exp_addr[c]) begin
        n_fail++; $display("FAIL cont_dm[%0d]: rd %b addr %h exp %b/%h", c, DM_READ, DM_ADDR, exp_rd[c], exp_addr[c]); end
      n_tests++; if (MEM_STALL !== exp_stall[c] || NI_DONE !== exp_done[c]) begin
        n_fail++; $display("FAIL cont_ctl[%0d]: stall %0b done %0b exp %0b/%0b", c, MEM_STALL, NI_DONE, exp_stall[c], exp_done[c]); end
      n_tests++; if (dut.cnt_q !== exp_cnt[c]) begin n_fail++; $display("FAIL cont_cnt[%0d]: got %0d exp %0d", c, dut.cnt_q, exp_cnt[c]); end
    end
    n_tests++; if (NI_RDATA !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL cont_ni_rdata: got %h exp 0badcafe", NI_RDATA); end
    tick();
    NI_REQ = 1'b0;
    #1;
    n_tests++; if (MEM_STALL !== 1'b1 || DM_READ !== 4'b0000) begin n_fail++; $display("FAIL cont_post_idle: stall %0b rd %b exp 1/0000", MEM_STALL, DM_READ); end
    tick(); #1;
    n_tests++; if (MEM_STALL !== 1'b0 || DM_ADDR !== 32'h44) begin n_fail++; $display("FAIL cont_post_cpu: stall %0b addr %h exp 0/44", MEM_STALL, DM_ADDR); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h48;
    NI_REQ = 1'b1; NI_WE = 1'b1; NI_ADDR = 32'h300; NI_WDATA = 32'hA5;
    tick(); #1;
    n_tests++; if (DM_READ !== 4'b1010 || DM_ADDR !== 32'h48 || NI_DONE !== 1'b0) begin
      n_fail++; $display("FAIL sim_cpu_first: rd %b addr %h done %0b exp 1010/48/0", DM_READ, DM_ADDR, NI_DONE); end
    tick();
    MEM_DATA_MEM_READ = 4'b0000;
    #1;
    n_tests++; if (DM_WRITE !== 3'b000 || NI_DONE !== 1'b0) begin n_fail++; $display("FAIL sim_idle: wr %b done %0b exp 000/0", DM_WRITE, NI_DONE); end
    tick(); #1;
    n_tests++; if (DM_WRITE !== 3'b110 || DM_ADDR !== 32'h300 || DM_WDATA !== 32'hA5 || NI_DONE !== 1'b1) begin
      n_fail++; $display("FAIL sim_ni_second: wr %b addr %h wd %h done %0b exp 110/300/a5/1", DM_WRITE, DM_ADDR, DM_WDATA, NI_DONE); end
    tick();
    idle_inputs();
    #1;
    n_tests++; if (NI_DONE !== 1'b0) begin n_fail++; $display("FAIL sim_done_pulse: got %0b exp 0", NI_DONE); end
    tick();
  endtask

  task automatic test_reset_mid_ni();
    NI_REQ = 1'b1; NI_WE = 1'b0; NI_ADDR = 32'h400; DM_BUSYWAIT = 1'b1; DM_RDATA = 32'h77;
    tick();
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h4C;
    #1;
    n_tests++; if (DM_READ !== 4'b1010 || DM_ADDR !== 32'h400 || NI_DONE !== 1'b0 || MEM_STALL !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: rd %b addr %h done %0b stall %0b exp 1010/400/0/1", DM_READ, DM_ADDR, NI_DONE, MEM_STALL); end
    RESET = 1'b0;
    #1;
    n_tests++; if (DM_READ !== 4'h0 || DM_ADDR !== 32'h0 || NI_DONE !== 1'b0 || MEM_STALL !== 1'b0 || MEM_READ_DATA !== 32'h0) begin
      n_fail++; $display("FAIL rmid_async: rd %b addr %h done %0b stall %0b mrd %h exp all 0", DM_READ, DM_ADDR, NI_DONE, MEM_STALL, MEM_READ_DATA); end
    DM_BUSYWAIT = 1'b0;
    tick(); #1;
    n_tests++; if (NI_DONE !== 1'b0 || DM_READ !== 4'h0) begin n_fail++; $display("FAIL rmid_held: done %0b rd %b exp 0/0000", NI_DONE, DM_READ); end
    MEM_DATA_MEM_READ = 4'b0000;
    RESET = 1'b1;
    #1;
    n_tests++; if (DM_READ !== 4'h0 || NI_DONE !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: rd %b done %0b exp 0000/0", DM_READ, NI_DONE); end
    tick(); #1;
    n_tests++; if (DM_READ !== 4'b1010 || DM_ADDR !== 32'h400 || NI_DONE !== 1'b1 || NI_RDATA !== 32'h77) begin
      n_fail++; $display("FAIL rmid_regrant: rd %b addr %h done %0b nrd %h exp 1010/400/1/77", DM_READ, DM_ADDR, NI_DONE, NI_RDATA); end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_lw();
    test_cpu_sw_busy();
    test_ni_write();
    test_contention();
    test_simultaneous();
    test_reset_mid_ni();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end, %0d of %0d comparisons failed so far", n_fail, n_tests);
    $fatal(1);
  end

endmodule
